// File: rtl/coaster_pkg.sv
// Shared encodings for the coaster track controller: FSM states, actuator
// command codes, fault codes and default dispatch weight bounds.
package coaster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    localparam logic [2:0] SPD_ACCEL = 3'b100;
    localparam logic [2:0] SPD_DECEL = 3'b010;
    localparam logic [2:0] SPD_EMERG = 3'b001;
    localparam logic [2:0] SPD_HOLD  = 3'b000;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_SEQ     = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    localparam int WEIGHT_MIN_DEF = 200;
    localparam int WEIGHT_MAX_DEF = 2000;

endpackage

// File: rtl/coaster_limit_sel.sv
// Selects the speed window of one segment from the packed limit vectors and
// compares the measured speed against it: cmp[0] = over Vmax, cmp[1] = under Vmin.
module coaster_limit_sel #(
    parameter int                       N_SEG     = 4,
    parameter int                       W_SPD     = 9,
    parameter logic [N_SEG*W_SPD-1:0]   V_MAX_VEC = {9'd30, 9'd20, 9'd50, 9'd30},
    parameter logic [N_SEG*W_SPD-1:0]   V_MIN_VEC = {9'd10, 9'd10, 9'd20, 9'd5}
) (
    input  logic [$clog2(N_SEG)-1:0] seg,
    input  logic [W_SPD-1:0]         speed,
    output logic [1:0]               cmp
);

    logic [W_SPD-1:0] v_max;
    logic [W_SPD-1:0] v_min;

    // Segment 0 sits in the LSBs of each packed vector.
    assign v_max = V_MAX_VEC[int'(seg)*W_SPD +: W_SPD];
    assign v_min = V_MIN_VEC[int'(seg)*W_SPD +: W_SPD];

    assign cmp = {speed < v_min, speed > v_max};

endmodule

// File: rtl/coaster_track_ctrl.sv
// Ride controller: dispatches the car from the loading position, tracks it
// segment by segment from the IR chain, regulates speed and latches faults.
module coaster_track_ctrl
    import coaster_pkg::*;
#(
    parameter int                       N_SEG       = 4,
    parameter int                       W_WT        = 12,
    parameter int                       W_SPD       = 9,
    parameter int                       WEIGHT_MIN  = WEIGHT_MIN_DEF,
    parameter int                       WEIGHT_MAX  = WEIGHT_MAX_DEF,
    parameter logic [N_SEG*W_SPD-1:0]   V_MAX_VEC   = {9'd30, 9'd20, 9'd50, 9'd30},
    parameter logic [N_SEG*W_SPD-1:0]   V_MIN_VEC   = {9'd10, 9'd10, 9'd20, 9'd5},
    parameter int                       SEG_TIMEOUT = 1000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [W_WT-1:0]          i_weight,
    input  logic                     i_start,
    input  logic [W_SPD-1:0]         i_speed,
    input  logic [N_SEG:0]           i_sensor,
    input  logic                     i_fault_clr,
    output logic [2:0]               o_speed_control,
    output logic [1:0]               o_state,
    output logic [$clog2(N_SEG)-1:0] o_seg,
    output logic [1:0]               o_alarm,
    output logic [W_WT-1:0]          o_f_push,
    output logic [W_WT-1:0]          o_f_brake,
    output logic                     o_destination,
    output logic [1:0]               o_fault_code
);

    localparam int SW = $clog2(N_SEG);
    localparam int TW = $clog2(SEG_TIMEOUT);

    localparam logic [W_WT-1:0]  WT_MIN      = W_WT'(WEIGHT_MIN);
    localparam logic [W_WT-1:0]  WT_MAX      = W_WT'(WEIGHT_MAX);
    localparam logic [TW-1:0]    TMR_LAST    = TW'(SEG_TIMEOUT - 1);
    localparam logic [SW-1:0]    SEG_LAST    = SW'(N_SEG - 1);
    localparam logic [N_SEG:0]   SENSOR_HOME = (N_SEG + 1)'(1);

    state_t          state_q, state_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [W_WT-1:0] wt_q, wt_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [W_WT-1:0] push_q, push_d;
    logic [W_WT-1:0] brake_q, brake_d;
    logic            dest_q, dest_d;
    logic [1:0]      fc_q, fc_d;
    logic [1:0]      alarm_q;

    logic [1:0]      cmp;
    logic [N_SEG:0]  own_mask, exp_mask;
    logic            illegal_hit, exp_hit, wt_ok, at_home;

    // Limits are indexed by the registered segment, so a new window applies
    // from the cycle after the segment change.
    coaster_limit_sel #(
        .N_SEG     (N_SEG),
        .W_SPD     (W_SPD),
        .V_MAX_VEC (V_MAX_VEC),
        .V_MIN_VEC (V_MIN_VEC)
    ) u_limit_sel (
        .seg   (seg_q),
        .speed (i_speed),
        .cmp   (cmp)
    );

    assign own_mask    = SENSOR_HOME << seg_q;
    assign exp_mask    = own_mask << 1;
    assign illegal_hit = |(i_sensor & ~(own_mask | exp_mask));
    assign exp_hit     = |(i_sensor & exp_mask);
    assign wt_ok       = (i_weight > WT_MIN) && (i_weight < WT_MAX);
    assign at_home     = (i_sensor == SENSOR_HOME);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        tmr_d   = tmr_q;
        wt_d    = wt_q;
        fc_d    = fc_q;
        ctrl_d  = SPD_HOLD;
        push_d  = '0;
        brake_d = '0;
        dest_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start && wt_ok && at_home) begin
                    state_d = ST_RUN;
                    wt_d    = i_weight;
                    seg_d   = '0;
                    tmr_d   = '0;
                end
            end
            ST_RUN: begin
                if (cmp[0]) begin
                    ctrl_d  = SPD_DECEL;
                    brake_d = wt_q;
                end else if (cmp[1]) begin
                    ctrl_d  = SPD_ACCEL;
                    push_d  = wt_q;
                end
                // Sequence errors beat an expected hit; an expected hit beats timeout.
                if (illegal_hit) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_SEQ;
                    ctrl_d  = SPD_EMERG;
                    push_d  = '0;
                    brake_d = wt_q;
                end else if (exp_hit) begin
                    tmr_d = '0;
                    if (seg_q == SEG_LAST) begin
                        state_d = ST_IDLE;
                        seg_d   = '0;
                        dest_d  = 1'b1;
                        ctrl_d  = SPD_HOLD;
                        push_d  = '0;
                        brake_d = '0;
                    end else begin
                        seg_d = seg_q + 1'b1;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_FAULT;
                    fc_d    = FC_TIMEOUT;
                    ctrl_d  = SPD_EMERG;
                    push_d  = '0;
                    brake_d = wt_q;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_FAULT: begin
                if (i_fault_clr && at_home) begin
                    state_d = ST_IDLE;
                    fc_d    = FC_NONE;
                    seg_d   = '0;
                    tmr_d   = '0;
                end else begin
                    ctrl_d  = SPD_EMERG;
                    brake_d = wt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
            tmr_q   <= '0;
            wt_q    <= '0;
            ctrl_q  <= SPD_HOLD;
            push_q  <= '0;
            brake_q <= '0;
            dest_q  <= 1'b0;
            fc_q    <= FC_NONE;
            alarm_q <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            tmr_q   <= tmr_d;
            wt_q    <= wt_d;
            ctrl_q  <= ctrl_d;
            push_q  <= push_d;
            brake_q <= brake_d;
            dest_q  <= dest_d;
            fc_q    <= fc_d;
            alarm_q <= {i_weight < WT_MIN, i_weight > WT_MAX};
        end
    end

    assign o_state         = state_q;
    assign o_seg           = seg_q;
    assign o_speed_control = ctrl_q;
    assign o_f_push        = push_q;
    assign o_f_brake       = brake_q;
    assign o_destination   = dest_q;
    assign o_fault_code    = fc_q;
    assign o_alarm         = alarm_q;

endmodule
